// File: rtl/dsp_sched_pkg.sv
// Shared types and rate helpers for the DSP toggle-rate sequencer.
// Rates are percent of a 100-cycle window, carried in 7 bits.
package dsp_sched_pkg;

  localparam int RATE_W   = 7;
  localparam int RATE_MAX = 100;

  typedef logic [RATE_W-1:0] rate_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STAGGER   = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_DWELL     = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  function automatic rate_t rate_clamp(input rate_t r);
    return (r > rate_t'(RATE_MAX)) ? rate_t'(RATE_MAX) : r;
  endfunction

  // 8-bit sums so rate+step never wraps before the limit test
  function automatic rate_t rate_add(input rate_t r,
                                     input logic [7:0] step,
                                     input rate_t lim);
    logic [7:0] s;
    s = {1'b0, r} + step;
    return (s > {1'b0, lim}) ? lim : s[RATE_W-1:0];
  endfunction

  function automatic rate_t rate_sub(input rate_t r,
                                     input logic [7:0] step);
    logic [7:0] s;
    s = {1'b0, r} - step;
    return ({1'b0, r} > step) ? s[RATE_W-1:0] : '0;
  endfunction

endpackage

// File: rtl/dsp_sched_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
// One instance serves the stagger, step and dwell phases in turn.
module dsp_sched_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = val_i;
    else if (!tc_o) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dsp_toggle_sched.sv
// Power-stress sequencer: staggered group enable, rate ramp up,
// hold, ramp down; abort forces a controlled ramp-down.
module dsp_toggle_sched
  import dsp_sched_pkg::*;
#(
  parameter int NUM_GROUPS    = 4,
  parameter int RAMP_STEP     = 5,
  parameter int STEP_INTERVAL = 16,
  parameter int STAGGER_CYC   = 8,
  parameter int DWELL_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [6:0]            cmd_target,
  input  logic [DWELL_W-1:0]    cmd_dwell,
  input  logic                  abort,
  output logic [6:0]            toggle_rate,
  output logic [NUM_GROUPS-1:0] group_en,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_o
);

  localparam int SW =
    $clog2(STEP_INTERVAL + STAGGER_CYC) + 1;
  localparam int TW = (DWELL_W > SW) ? DWELL_W : SW;

  localparam logic [TW-1:0] STEP_LD = TW'(STEP_INTERVAL - 1);
  localparam logic [TW-1:0] STAG_LD = TW'(STAGGER_CYC - 1);
  localparam logic [7:0]    STEP8   = 8'(RAMP_STEP);
  localparam logic [NUM_GROUPS-1:0] EN0 = NUM_GROUPS'(1);

  state_e                 state_q;
  rate_t                  rate_q;
  rate_t                  tgt_q;
  logic [DWELL_W-1:0]     dwell_q;
  logic [NUM_GROUPS-1:0]  en_q;
  logic                   done_q;

  logic          ld;
  logic [TW-1:0] ld_val;
  logic          tc;
  logic          at_tgt;
  logic          dwell_tc;
  logic [TW-1:0] dwell_ld;

  assign at_tgt   = (rate_q == tgt_q);
  assign dwell_tc = (dwell_q != '0) && tc;
  assign dwell_ld = TW'(dwell_q) - TW'(1);

  // Reload on every phase entry and every step expiry
  always_comb begin
    ld     = 1'b0;
    ld_val = STEP_LD;
    unique case (state_q)
      S_IDLE: begin
        ld     = cmd_valid;
        ld_val = STAG_LD;
      end
      S_STAGGER: begin
        ld = abort | tc;
        if (!abort && !en_q[NUM_GROUPS-1])
          ld_val = STAG_LD;
      end
      S_RAMP_UP: begin
        ld = abort | at_tgt | tc;
        if (!abort && at_tgt)
          ld_val = dwell_ld;
      end
      S_DWELL:     ld = abort | dwell_tc;
      S_RAMP_DOWN: ld = tc;
      default:     ld = 1'b0;
    endcase
  end

  dsp_sched_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld),
    .val_i  (ld_val),
    .tc_o   (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rate_q  <= '0;
      tgt_q   <= '0;
      dwell_q <= '0;
      en_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (cmd_valid) begin
          tgt_q   <= rate_clamp(cmd_target);
          dwell_q <= cmd_dwell;
          en_q    <= EN0;
          state_q <= S_STAGGER;
        end
        S_STAGGER:
          if (abort) state_q <= S_RAMP_DOWN;
          else if (tc) begin
            if (en_q[NUM_GROUPS-1]) state_q <= S_RAMP_UP;
            else en_q <= (en_q << 1) | EN0;
          end
        S_RAMP_UP:
          if (abort) begin
            if (tc && !at_tgt)
              rate_q <= rate_add(rate_q, STEP8, tgt_q);
            state_q <= S_RAMP_DOWN;
          end else if (at_tgt) state_q <= S_DWELL;
          else if (tc) rate_q <= rate_add(rate_q, STEP8, tgt_q);
        S_DWELL:
          if (abort || dwell_tc) state_q <= S_RAMP_DOWN;
        S_RAMP_DOWN:
          if (rate_q == '0) begin
            en_q    <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (tc) rate_q <= rate_sub(rate_q, STEP8);
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign toggle_rate = rate_q;
  assign group_en    = en_q;
  assign busy        = (state_q != S_IDLE);
  assign cmd_ready   = (state_q == S_IDLE);
  assign done        = done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_dsp_toggle_sched.sv
// Bench for dsp_toggle_sched: per-cycle comparison against a
// closed-form timeline of each command (stagger, ramps, dwell, abort).
module tb_dsp_toggle_sched;

  localparam int NG  = 4;
  localparam int RS  = 5;
  localparam int SI  = 16;
  localparam int SC  = 8;
  localparam int INF = 1 << 29;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [6:0]    cmd_target = '0;
  logic [15:0]   cmd_dwell = '0;
  logic          abort = 1'b0;
  logic [6:0]    toggle_rate;
  logic [NG-1:0] group_en;
  logic          busy;
  logic          done;
  logic [2:0]    state_o;

  logic       c7_valid = 1'b0;
  logic       c7_ready;
  logic [6:0] c7_tgt = '0;
  logic [7:0] c7_dwell = '0;
  logic       c7_abort = 1'b0;
  logic [6:0] c7_rate;
  logic [1:0] c7_en;
  logic       c7_busy;
  logic       c7_done;
  logic [2:0] c7_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsp_toggle_sched #(
    .NUM_GROUPS(NG), .RAMP_STEP(RS), .STEP_INTERVAL(SI),
    .STAGGER_CYC(SC), .DWELL_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_dwell(cmd_dwell),
    .abort(abort), .toggle_rate(toggle_rate),
    .group_en(group_en), .busy(busy), .done(done),
    .state_o(state_o)
  );

  dsp_toggle_sched #(
    .NUM_GROUPS(2), .RAMP_STEP(7), .STEP_INTERVAL(4),
    .STAGGER_CYC(3), .DWELL_W(8)
  ) dut7 (
    .clk(clk), .rst(rst),
    .cmd_valid(c7_valid), .cmd_ready(c7_ready),
    .cmd_target(c7_tgt), .cmd_dwell(c7_dwell),
    .abort(c7_abort), .toggle_rate(c7_rate),
    .group_en(c7_en), .busy(c7_busy), .done(c7_done),
    .state_o(c7_state)
  );

  // k counts cycles after the accepting edge; the plan gives the
  // cycle each phase begins, from which every output follows.
  task automatic run_cmd(input int tin, input int d, input int a,
                         input bit hold, input int rst_k);
    int t, n, u0, w0, r0, r0n, rs, m, dn, er, kk, g;
    logic [NG-1:0] een;
    t   = (tin > 100) ? 100 : tin;
    u0  = NG * SC;
    n   = (t + RS - 1) / RS;
    w0  = u0 + n * SI + 1;
    r0n = (d == 0) ? INF : w0 + d;
    if (a >= 0 && a < r0n) begin
      r0 = a + 1;
      if (r0 >= w0) rs = t;
      else if (r0 >= u0) begin
        rs = ((r0 - u0) / SI) * RS;
        if (rs > t) rs = t;
      end else rs = 0;
    end else begin
      r0 = r0n;
      rs = t;
    end
    m  = (rs + RS - 1) / RS;
    dn = (r0 >= INF) ? INF : r0 + m * SI + 1;
    checks++;
    if (dn > 20000) begin
      failures++;
      $display("FAIL plan_bound dn=%0d limit=20000", dn);
      return;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_idle got=%b exp=1", cmd_ready);
    end
    cmd_valid  = 1'b1;
    cmd_target = 7'(tin);
    cmd_dwell  = 16'(d);
    @(posedge clk); #1;
    for (int k = 0; k <= dn + 1; k++) begin
      if (k == rst_k) begin
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({toggle_rate, group_en, busy, done, cmd_ready}
            !== {7'd0, {NG{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL async_rst rate=%0d en=%b busy=%b exp 0/0/0",
                   toggle_rate, group_en, busy);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        return;
      end
      if (k >= dn) er = 0;
      else if (k >= r0) begin
        er = rs - ((k - r0) / SI) * RS;
        if (er < 0) er = 0;
      end else if (k >= w0) er = t;
      else if (k >= u0) begin
        er = ((k - u0) / SI) * RS;
        if (er > t) er = t;
      end else er = 0;
      kk  = (k >= r0) ? r0 - 1 : k;
      g   = kk / SC + 1;
      if (g > NG) g = NG;
      een = (k >= dn) ? '0 : NG'((1 << g) - 1);
      checks++;
      if (toggle_rate !== 7'(er)) begin
        failures++;
        if (failures < 40)
          $display("FAIL rate k=%0d got=%0d exp=%0d",
                   k, toggle_rate, er);
      end
      checks++;
      if (group_en !== een) begin
        failures++;
        if (failures < 40)
          $display("FAIL group_en k=%0d got=%b exp=%b",
                   k, group_en, een);
      end
      checks++;
      if (busy !== (k <= dn)) begin
        failures++;
        if (failures < 40)
          $display("FAIL busy k=%0d got=%b exp=%b", k, busy, k <= dn);
      end
      checks++;
      if (done !== (k == dn)) begin
        failures++;
        if (failures < 40)
          $display("FAIL done k=%0d got=%b exp=%b", k, done, k == dn);
      end
      checks++;
      if (cmd_ready !== (k > dn)) begin
        failures++;
        if (failures < 40)
          $display("FAIL cmd_ready k=%0d got=%b exp=%b",
                   k, cmd_ready, k > dn);
      end
      if (k == dn + 1) break;
      abort      = (a >= 0 && k >= a);
      cmd_valid  = hold ? 1'b1 : 1'($urandom);
      cmd_target = 7'($urandom);
      cmd_dwell  = 16'($urandom);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (toggle_rate !== 7'd0 || group_en !== '0) begin
      failures++;
      $display("FAIL reset_out rate=%0d en=%b exp 0", toggle_rate, group_en);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b rdy=%b exp 0/0/1",
               busy, done, cmd_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || c7_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset rdy=%b busy=%b rdy7=%b exp 1/0/1",
               cmd_ready, busy, c7_ready);
    end
  endtask

  task automatic test_basic;
    run_cmd(20, 50, -1, 1'b0, -1);
  endtask

  task automatic test_clamp;
    run_cmd(127, 5, -1, 1'b0, -1);
    run_cmd(101, 2, -1, 1'b0, -1);
  endtask

  task automatic test_step7;
    int expq[$];
    int seen[$];
    int v, prev, cyc;
    v = 0;
    while (v < 20) begin
      v = (v + 7 > 20) ? 20 : v + 7;
      expq.push_back(v);
    end
    while (v > 0) begin
      v = (v > 7) ? v - 7 : 0;
      expq.push_back(v);
    end
    c7_valid = 1'b1;
    c7_tgt   = 7'd20;
    c7_dwell = 8'd3;
    @(posedge clk); #1;
    c7_valid = 1'b0;
    prev = 0;
    cyc  = 0;
    while (c7_done !== 1'b1 && cyc < 500) begin
      if (int'(c7_rate) != prev) begin
        seen.push_back(int'(c7_rate));
        prev = int'(c7_rate);
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 500) begin
      failures++;
      $display("FAIL step7_timeout cycles=%0d limit=500", cyc);
    end
    checks++;
    if (seen.size() != expq.size()) begin
      failures++;
      $display("FAIL step7_len got=%0d exp=%0d", seen.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (seen[i] != expq[i]) begin
          failures++;
          $display("FAIL step7_rate i=%0d got=%0d exp=%0d",
                   i, seen[i], expq[i]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_target;
    run_cmd(0, 10, -1, 1'b0, -1);
  endtask

  task automatic test_abort;
    run_cmd(50, 30, 80, 1'b0, -1);
    run_cmd(40, 20, 10, 1'b0, -1);
    run_cmd(10, 0, 300, 1'b0, -1);
    run_cmd(35, 4, -1, 1'b0, -1);
  endtask

  task automatic test_async_reset;
    run_cmd(60, 200, -1, 1'b0, 240);
    run_cmd(25, 8, -1, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    run_cmd(15, 5, -1, 1'b1, -1);
    run_cmd(30, 3, -1, 1'b0, -1);
  endtask

  task automatic test_random;
    int tin, d, a;
    for (int i = 0; i < 6; i++) begin
      tin = $urandom_range(0, 127);
      d   = $urandom_range(0, 40);
      if (d == 0 || $urandom_range(0, 1) == 1)
        a = $urandom_range(0, 400);
      else
        a = -1;
      run_cmd(tin, d, a, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_clamp;
    test_step7;
    test_zero_target;
    test_abort;
    test_async_reset;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_toggle_sched.md
Name: dsp_toggle_sched

Overview:
- Power-stress sequencer for the DSP toggle arrays. It drives a shared 7-bit toggle rate (percent of a 100-cycle window) and per-group enables into NUM_GROUPS DSP stress instances.
- Groups are brought up staggered, and the rate is ramped up, held, then ramped down. This bounds di/dt on the supply during board power characterisation.
- One command is accepted at a time over a valid/ready interface; an abort forces a controlled ramp-down.

Parameters:
- NUM_GROUPS, 4, number of DSP stress groups (1..16)
- RAMP_STEP, 5, rate increment/decrement per step (1..100)
- STEP_INTERVAL, 16, cycles between ramp steps (>=1)
- STAGGER_CYC, 8, cycles between successive group enables (>=1)
- DWELL_W, 16, width of dwell counter

Ports:
- clk  in  1  single clock
- rst  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_target  in  7  target toggle rate; values >100 clamp to 100
- cmd_dwell  in  DWELL_W  hold cycles at target; 0 = hold until abort
- abort  in  1  level; forces ramp-down from any active state
- toggle_rate  out  7  rate to all DSP groups
- group_en  out  NUM_GROUPS  per-group enable (group held in reset when 0)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on return to IDLE
- state_o  out  3  current state encoding for debug

Behaviour:
- Reset (async assert, sync deassert at the consumer): state=IDLE, toggle_rate=0, group_en=0, busy=0, done=0, cmd_ready=1, all counters 0.
- States: IDLE, STAGGER, RAMP_UP, DWELL, RAMP_DOWN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch the clamped target and the dwell value, then go to STAGGER.
  - abort is ignored in IDLE.
- STAGGER:
  - group_en[0] rises on the first STAGGER cycle.
  - group_en[g] rises STAGGER_CYC cycles after group_en[g-1].
  - STAGGER_CYC cycles after the last bit rises, go to RAMP_UP.
  - toggle_rate stays 0 throughout.
- RAMP_UP:
  - The step timer starts at 0. When it reaches STEP_INTERVAL-1, toggle_rate = min(rate+RAMP_STEP, target) and the timer is cleared.
  - When toggle_rate==target (including target=0 on entry), go to DWELL next cycle.
  - Saturation arithmetic is done at 8 bits; there is no wrap.
- DWELL:
  - Count cmd_dwell cycles, then go to RAMP_DOWN.
  - If cmd_dwell=0, stay until abort.
- RAMP_DOWN:
  - Every STEP_INTERVAL cycles, toggle_rate = max(rate-RAMP_STEP, 0).
  - When toggle_rate==0, go to DONE. Entry with rate already 0 goes to DONE the next cycle.
- DONE:
  - group_en=0 (all bits at once), done=1 for this single cycle.
  - Go to IDLE next cycle.
- abort:
  - Sampled each cycle in STAGGER/RAMP_UP/DWELL and forces RAMP_DOWN on the next cycle.
  - The step timer is cleared and the current rate is kept; enabled groups stay enabled.
  - abort in RAMP_DOWN/DONE has no effect.
  - abort held into IDLE does not block a new command.
- Simultaneous events: a ramp-step expiry in the same cycle as abort applies the step first, then the transition.
- Reset mid-operation clears all outputs immediately (async). toggle_rate=0 and group_en=0 are the safe state.
- Latched target/dwell are stable for the whole command. Input changes while busy are ignored.

Decomposition:
- Package dsp_sched_pkg:
  - state enum (3-bit)
  - RATE_MAX=100 and RATE_W=7 constants
  - a saturating add/sub function on rate.
- One sub-module, dsp_sched_timer: a loadable down-counter with a terminal-count pulse. It is shared by the stagger, step and dwell phases; only one phase is active at a time.

Test Plan:
- Basic run, defaults, target=20, dwell=50:
  - group_en goes 0001→0011→0111→1111 at cycles 0,8,16,24 after acceptance.
  - RAMP_UP starts at cycle 32; rate goes 5,10,15,20 at 16-cycle spacing.
  - DWELL lasts 50 cycles; rate ramps down 15,10,5,0; done pulses once; cmd_ready returns to 1.
- Clamp/saturate: target=127 → latched 100; rate steps 5..100 in 20 steps, never exceeds 100.
  - Separately, RAMP_STEP=7, target=20 → rate 7,14,20.
- Target=0, dwell=10: rate never leaves 0; DWELL entered at cycle 33; DONE after 10 dwell cycles plus 1 cycle.
- Abort:
  - Abort at the rate-15 step in RAMP_UP (target=50) → ramp-down 10,5,0; done pulse.
  - Abort during STAGGER after 2 groups → DONE next cycle after RAMP_DOWN, group_en→0.
  - dwell=0 holds indefinitely until abort.
- Async reset asserted mid-DWELL at rate=60 → same-cycle toggle_rate=0, group_en=0, busy=0. A new command after deassert runs normally.
- Back-to-back: cmd_valid held high across done → second command accepted on the first IDLE cycle; no command is accepted while busy.
